i2c_passthru_bitrx: RTL and testbench
=====================================

I2C_PASSTHRU_BITRX -- requirements
Module: i2c_passthru_bitrx

Interface
REQ-001 SHALL have parameter F_REF_T_LOW, default 20: number of i_f_ref rising edges in one timed SCL phase (20 × 250 ns = 5 us).
REQ-002 SHALL have parameter WIDTH_F_REF_T_LOW, default 5: width of the phase counter.
REQ-003 SHALL have port i_clk, input, 1: the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port i_rstn, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port i_f_ref, input, 1: reference square wave, already synchronous to i_clk; only its rising edges count.
REQ-006 SHALL have ports i_start_rx, i_rx_frm_slv, i_tx_done, i_scl, i_sda, all inputs, 1 bit each:
- i_start_rx: start a bit.
- i_rx_frm_slv: bit source is the slave (1) or the master (0); latched on start.
- i_tx_done: the downstream transmitter has finished.
- i_scl, i_sda: synchronized bus levels.
REQ-007 SHALL have outputs, all registered, 1 bit each:
- o_rx_sda_init_valid, o_rx_sda_init: SDA sampled at the SCL rise is valid, and its value.
- o_rx_sda_mid_change: SDA changed while SCL was high (START/STOP).
- o_rx_sda_final: last SDA value while SCL was high.
- o_scl: drive SCL; 0 pulls low, 1 releases.
- o_sda: drive SDA.
- o_rx_done: bit received.
- o_violation: protocol violation.

Function
REQ-008 SHALL implement the states LOW, RELEASE, HIGH, HOLD and DONE.
REQ-009 SHALL, when i_start_rx=1 in any state, go to LOW at the next edge, latch i_rx_frm_slv, and clear the counter, rx_done, init_valid and mid_change; i_start_rx has priority over i_tx_done.
REQ-010 SHALL, in LOW, hold o_scl=0 and count i_f_ref rising edges; on reaching F_REF_T_LOW it goes to RELEASE.
REQ-011 SHALL, in RELEASE, set o_scl=1 and wait; when it samples i_scl=1 it goes to HIGH with init_valid=1 and init=i_sda, one cycle after the rise.
REQ-012 SHALL, in HIGH, hold o_scl=1 and update final=i_sda every cycle; i_sda differing from init sets mid_change=1 one cycle later.
REQ-013 SHALL end HIGH in master mode on sampling i_scl=0: at the next edge it goes to HOLD with o_scl=0 and rx_done=1.
REQ-014 SHALL end HIGH in slave mode after F_REF_T_LOW i_f_ref edges counted from entering HIGH, regardless of i_scl: it then goes to HOLD with o_scl=0 and rx_done=1.
REQ-015 SHALL, in slave mode during HIGH, set o_violation=1 one cycle after i_sda differs from init.
REQ-016 SHALL, in HOLD, keep o_scl=0, rx_done=1 and init_valid; on i_tx_done=1 it goes to DONE.
REQ-017 SHALL, in DONE, keep o_scl=0 and rx_done=1 with init_valid=0 and mid_change=0, ignore i_scl/i_sda, and wait for i_start_rx.
REQ-018 SHALL keep o_sda=1 at all times (the receiver never drives SDA).
REQ-019 SHALL keep o_violation sticky until reset or i_start_rx.

Reset
REQ-020 SHALL, on i_rstn=0, immediately enter RELEASE in master mode with o_scl=1, o_sda=1, the counter at 0, and all other outputs 0.

Configuration
REQ-021 SHALL, with I2C_BITRX_SCL_CHECK_EN defined, set o_violation when i_scl=0 is sampled in slave-mode HIGH before the counter expires; without it, that event SHALL be ignored.

Structure
REQ-022 SHALL take the state enum and the default T_LOW constants from the shared package i2c_passthru_pkg.
REQ-023 SHALL place edge detection and the phase counter in the sub-module i2c_passthru_tref_timer.

Verification
All scenarios use a 50 MHz i_clk and a 4 MHz i_f_ref.
REQ-024 Reset with scl=1, sda=1, then one clock -> init_valid=1, init=1, o_scl=1, rx_done=0.
REQ-025 From REQ-024, set sda=0 -> mid_change=1; then scl=0 -> o_scl=0, rx_done=1; then tx_done=1 -> init_valid=0, mid_change=0, rx_done=1.
REQ-026 Start a slave-mode bit with sda=0 -> o_scl=0 for 4–6 us with rx_done=0, then o_scl=1; set scl=1 -> init_valid=1, init=0 after one clock.
REQ-027 Continue REQ-026 with i_scl held high -> outputs stable for ≥4 us, then o_scl=0 and rx_done=1 within 6 us; tx_done -> init_valid=0.
REQ-028 Slave-mode bit with init=1, then sda=0 during HIGH -> o_violation=1 after one clock.
REQ-029 Master-mode bit with an SDA change during HIGH -> mid_change=1 and o_violation=0.

Source files
------------

// File: rtl/i2c_passthru_pkg.sv
// Shared types and default timing constants for the I2C pass-through blocks.
package i2c_passthru_pkg;

  typedef enum logic [2:0] {
    ST_LOW,
    ST_RELEASE,
    ST_HIGH,
    ST_HOLD,
    ST_DONE
  } bitrx_state_t;

  // One SCL phase: 20 reference edges at 4 MHz = 5 us.
  localparam int F_REF_T_LOW_DEFAULT       = 20;
  localparam int WIDTH_F_REF_T_LOW_DEFAULT = 5;

endpackage

// File: rtl/i2c_passthru_tref_timer.sv
// Counts rising edges of the reference square wave and flags the edge that
// completes one timed SCL phase.
module i2c_passthru_tref_timer #(
  parameter int F_REF_T_LOW       = 20,
  parameter int WIDTH_F_REF_T_LOW = 5
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_f_ref,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [WIDTH_F_REF_T_LOW-1:0] LAST_CNT = WIDTH_F_REF_T_LOW'(F_REF_T_LOW - 1);

  logic                         f_ref_q, f_ref_d;
  logic [WIDTH_F_REF_T_LOW-1:0] cnt_q, cnt_d;
  logic                         f_ref_rise;

  assign f_ref_rise = i_f_ref & ~f_ref_q;
  assign o_expired  = i_en & f_ref_rise & (cnt_q == LAST_CNT);

  always_comb begin
    f_ref_d = i_f_ref;
    cnt_d   = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en && f_ref_rise) begin
      // Wrap on expiry so the next phase starts from zero without a clear.
      cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      f_ref_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      f_ref_q <= f_ref_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/i2c_passthru_bitrx.sv
// Single-bit I2C receiver stretching/timing SCL for the pass-through bridge.
// Optional: define I2C_BITRX_SCL_CHECK_EN to flag early SCL low in slave HIGH.
module i2c_passthru_bitrx
  import i2c_passthru_pkg::*;
#(
  parameter int F_REF_T_LOW       = F_REF_T_LOW_DEFAULT,
  parameter int WIDTH_F_REF_T_LOW = WIDTH_F_REF_T_LOW_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_f_ref,
  input  logic i_start_rx,
  input  logic i_rx_frm_slv,
  input  logic i_tx_done,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_rx_sda_init_valid,
  output logic o_rx_sda_init,
  output logic o_rx_sda_mid_change,
  output logic o_rx_sda_final,
  output logic o_scl,
  output logic o_sda,
  output logic o_rx_done,
  output logic o_violation
);

  bitrx_state_t state_q, state_d;
  logic slv_q, slv_d;
  logic init_valid_q, init_valid_d;
  logic init_q, init_d;
  logic mid_change_q, mid_change_d;
  logic final_q, final_d;
  logic scl_q, scl_d;
  logic sda_q, sda_d;
  logic rx_done_q, rx_done_d;
  logic violation_q, violation_d;

  logic timer_clr, timer_en, timer_expired;

  // The counter only runs while a phase is being timed; elsewhere it is held at zero.
  assign timer_clr = i_start_rx | ~((state_q == ST_LOW) | (state_q == ST_HIGH));
  assign timer_en  = (state_q == ST_LOW) | ((state_q == ST_HIGH) & slv_q);

  i2c_passthru_tref_timer #(
    .F_REF_T_LOW       (F_REF_T_LOW),
    .WIDTH_F_REF_T_LOW (WIDTH_F_REF_T_LOW)
  ) u_tref_timer (
    .i_clk     (i_clk),
    .i_rstn    (i_rstn),
    .i_f_ref   (i_f_ref),
    .i_clr     (timer_clr),
    .i_en      (timer_en),
    .o_expired (timer_expired)
  );

  always_comb begin
    state_d      = state_q;
    slv_d        = slv_q;
    init_valid_d = init_valid_q;
    init_d       = init_q;
    mid_change_d = mid_change_q;
    final_d      = final_q;
    rx_done_d    = rx_done_q;
    violation_d  = violation_q;
    sda_d        = 1'b1;

    case (state_q)
      ST_LOW: begin
        if (timer_expired) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        // SCL may be held low by a stretching peer; wait until it is really high.
        if (i_scl) begin
          state_d      = ST_HIGH;
          init_valid_d = 1'b1;
          init_d       = i_sda;
          final_d      = i_sda;
        end
      end
      ST_HIGH: begin
        final_d = i_sda;
        if (i_sda != init_q) begin
          mid_change_d = 1'b1;
          if (slv_q) violation_d = 1'b1;
        end
        if (slv_q) begin
          if (timer_expired) begin
            state_d   = ST_HOLD;
            rx_done_d = 1'b1;
          end
`ifdef I2C_BITRX_SCL_CHECK_EN
          else if (!i_scl) begin
            violation_d = 1'b1;
          end
`endif
        end else if (!i_scl) begin
          state_d   = ST_HOLD;
          rx_done_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (i_tx_done) begin
          state_d      = ST_DONE;
          init_valid_d = 1'b0;
          mid_change_d = 1'b0;
        end
      end
      ST_DONE: begin
      end
      default: state_d = ST_RELEASE;
    endcase

    if (i_start_rx) begin
      state_d      = ST_LOW;
      slv_d        = i_rx_frm_slv;
      init_valid_d = 1'b0;
      mid_change_d = 1'b0;
      rx_done_d    = 1'b0;
      violation_d  = 1'b0;
    end

    scl_d = (state_d == ST_RELEASE) | (state_d == ST_HIGH);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q      <= ST_RELEASE;
      slv_q        <= 1'b0;
      init_valid_q <= 1'b0;
      init_q       <= 1'b0;
      mid_change_q <= 1'b0;
      final_q      <= 1'b0;
      scl_q        <= 1'b1;
      sda_q        <= 1'b1;
      rx_done_q    <= 1'b0;
      violation_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      slv_q        <= slv_d;
      init_valid_q <= init_valid_d;
      init_q       <= init_d;
      mid_change_q <= mid_change_d;
      final_q      <= final_d;
      scl_q        <= scl_d;
      sda_q        <= sda_d;
      rx_done_q    <= rx_done_d;
      violation_q  <= violation_d;
    end
  end

  assign o_rx_sda_init_valid = init_valid_q;
  assign o_rx_sda_init       = init_q;
  assign o_rx_sda_mid_change = mid_change_q;
  assign o_rx_sda_final      = final_q;
  assign o_scl               = scl_q;
  assign o_sda               = sda_q;
  assign o_rx_done           = rx_done_q;
  assign o_violation         = violation_q;

endmodule

// File: tb/tb_i2c_passthru_bitrx.sv
// Scoreboard bench for i2c_passthru_bitrx: 50 MHz clock, 4 MHz reference.
module tb_i2c_passthru_bitrx;

  logic clk = 1'b0;
  logic rstn, f_ref, start_rx, rx_frm_slv, tx_done, scl, sda;
  logic init_valid, init_v, mid_change, final_v, o_scl, o_sda, rx_done, violation;
  logic [7:0] obs;

  // Packed order: init_valid, init, mid_change, final, o_scl, o_sda, rx_done, violation
  assign obs = {init_valid, init_v, mid_change, final_v, o_scl, o_sda, rx_done, violation};

  typedef struct {
    string      name;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks   = 0;
  int   failures = 0;

  i2c_passthru_bitrx dut (
    .i_clk               (clk),
    .i_rstn              (rstn),
    .i_f_ref             (f_ref),
    .i_start_rx          (start_rx),
    .i_rx_frm_slv        (rx_frm_slv),
    .i_tx_done           (tx_done),
    .i_scl               (scl),
    .i_sda               (sda),
    .o_rx_sda_init_valid (init_valid),
    .o_rx_sda_init       (init_v),
    .o_rx_sda_mid_change (mid_change),
    .o_rx_sda_final      (final_v),
    .o_scl               (o_scl),
    .o_sda               (o_sda),
    .o_rx_done           (rx_done),
    .o_violation         (violation)
  );

  always #10 clk = ~clk;

  // 4 MHz reference synchronous to the 50 MHz clock: two rises per 25 cycles.
  initial begin
    int ph;
    ph    = 0;
    f_ref = 1'b0;
    forever begin
      @(negedge clk);
      f_ref = (ph < 6) || (ph >= 12 && ph < 18);
      ph    = (ph == 24) ? 0 : ph + 1;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; start_rx = 1'b0; rx_frm_slv = 1'b0; tx_done = 1'b0;
    scl = 1'b1; sda = 1'b1;
    sb.push_back('{"reset_state", 8'b0000_1100});
    #25;
    e = sb.pop_front(); checks++;
    if (obs !== e.val) begin failures++; $display("FAIL %s: got %b expected %b", e.name, obs, e.val); end
    tick(1);
    rstn = 1'b1;
    sb.push_back('{"reset_first_high", 8'b1101_1100});
    tick(1);
    e = sb.pop_front(); checks++;
    if (obs !== e.val) begin failures++; $display("FAIL %s: got %b expected %b", e.name, obs, e.val); end
  endtask

  task automatic test_master_bit();
    sda = 1'b0;
    sb.push_back('{"m_mid_change", 8'b1110_1100});
    tick(1);
    e = sb.pop_front(); checks++;
    if (obs !== e.val) begin failures++; $display("FAIL %s: got %b expected %b", e.name, obs, e.val); end
    scl = 1'b0;
    sb.push_back('{"m_hold", 8'b1110_0110});
    tick(1);
    e = sb.pop_front(); checks++;
    if (obs !== e.val) begin failures++; $display("FAIL %s: got %b expected %b", e.name, obs, e.val); end
    tx_done = 1'b1;
    sb.push_back('{"m_done", 8'b0100_0110});
    tick(1);
    e = sb.pop_front(); checks++;
    if (obs !== e.val) begin failures++; $display("FAIL %s: got %b expected %b", e.name, obs, e.val); end
    tx_done = 1'b0; scl = 1'b1; sda = 1'b1;
    sb.push_back('{"m_done_ignores_bus", 8'b0100_0110});
    tick(3);
    e = sb.pop_front(); checks++;
    if (obs !== e.val) begin failures++; $display("FAIL %s: got %b expected %b", e.name, obs, e.val); end
  endtask

  task automatic test_slave_bit();
    int  n;
    bit  bad;
    sda = 1'b0; scl = 1'b0; rx_frm_slv = 1'b1; start_rx = 1'b1;
    sb.push_back('{"s_low_entry", 8'b0100_0100});
    tick(1);
    start_rx = 1'b0;
    e = sb.pop_front(); checks++;
    if (obs !== e.val) begin failures++; $display("FAIL %s: got %b expected %b", e.name, obs, e.val); end
    n = 0; bad = 1'b0;
    while (o_scl !== 1'b1 && n < 400) begin
      if (rx_done !== 1'b0) bad = 1'b1;
      tick(1); n++;
    end
    checks++;
    if (n < 200 || n > 300 || bad) begin
      failures++; $display("FAIL s_low_time: got %0d cycles (rx_done seen=%0d) expected 200..300 cycles", n, bad);
    end
    sb.push_back('{"s_release_wait", 8'b0100_1100});
    tick(1);
    e = sb.pop_front(); checks++;
    if (obs !== e.val) begin failures++; $display("FAIL %s: got %b expected %b", e.name, obs, e.val); end
    scl = 1'b1;
    sb.push_back('{"s_high_entry", 8'b1000_1100});
    tick(1);
    e = sb.pop_front(); checks++;
    if (obs !== e.val) begin failures++; $display("FAIL %s: got %b expected %b", e.name, obs, e.val); end
    n = 0; bad = 1'b0;
    while (o_scl === 1'b1 && n < 400) begin
      if (obs !== 8'b1000_1100) bad = 1'b1;
      tick(1); n++;
    end
    checks++;
    if (n < 200 || n > 300 || bad) begin
      failures++; $display("FAIL s_high_time: got %0d cycles (unstable=%0d) expected 200..300 stable cycles", n, bad);
    end
    sb.push_back('{"s_hold", 8'b1000_0110});
    e = sb.pop_front(); checks++;
    if (obs !== e.val) begin failures++; $display("FAIL %s: got %b expected %b", e.name, obs, e.val); end
    tx_done = 1'b1;
    sb.push_back('{"s_done", 8'b0000_0110});
    tick(1);
    tx_done = 1'b0;
    e = sb.pop_front(); checks++;
    if (obs !== e.val) begin failures++; $display("FAIL %s: got %b expected %b", e.name, obs, e.val); end
  endtask

  task automatic test_slave_violation();
    int n;
    sda = 1'b1; scl = 1'b0; rx_frm_slv = 1'b1; start_rx = 1'b1;
    tick(1);
    start_rx = 1'b0;
    n = 0;
    while (o_scl !== 1'b1 && n < 400) begin tick(1); n++; end
    checks++;
    if (n >= 400) begin failures++; $display("FAIL v_release_timeout: got %0d cycles expected <400", n); end
    scl = 1'b1;
    sb.push_back('{"v_high_entry", 8'b1101_1100});
    tick(1);
    e = sb.pop_front(); checks++;
    if (obs !== e.val) begin failures++; $display("FAIL %s: got %b expected %b", e.name, obs, e.val); end
    sda = 1'b0;
    sb.push_back('{"v_violation", 8'b1110_1101});
    tick(1);
    e = sb.pop_front(); checks++;
    if (obs !== e.val) begin failures++; $display("FAIL %s: got %b expected %b", e.name, obs, e.val); end
    n = 0;
    while (o_scl === 1'b1 && n < 400) begin tick(1); n++; end
    sb.push_back('{"v_hold_sticky", 8'b1110_0111});
    e = sb.pop_front(); checks++;
    if (obs !== e.val) begin failures++; $display("FAIL %s: got %b expected %b", e.name, obs, e.val); end
    tx_done = 1'b1;
    sb.push_back('{"v_done_sticky", 8'b0100_0111});
    tick(1);
    tx_done = 1'b0;
    e = sb.pop_front(); checks++;
    if (obs !== e.val) begin failures++; $display("FAIL %s: got %b expected %b", e.name, obs, e.val); end
    rx_frm_slv = 1'b0; start_rx = 1'b1;
    sb.push_back('{"v_cleared_by_start", 8'b0100_0100});
    tick(1);
    start_rx = 1'b0;
    e = sb.pop_front(); checks++;
    if (obs !== e.val) begin failures++; $display("FAIL %s: got %b expected %b", e.name, obs, e.val); end
  endtask

  task automatic test_master_change();
    int n;
    n = 0;
    while (o_scl !== 1'b1 && n < 400) begin tick(1); n++; end
    sb.push_back('{"mc_release", 8'b0100_1100});
    e = sb.pop_front(); checks++;
    if (obs !== e.val) begin failures++; $display("FAIL %s: got %b expected %b", e.name, obs, e.val); end
    sda = 1'b1; scl = 1'b1;
    sb.push_back('{"mc_high_entry", 8'b1101_1100});
    tick(1);
    e = sb.pop_front(); checks++;
    if (obs !== e.val) begin failures++; $display("FAIL %s: got %b expected %b", e.name, obs, e.val); end
    sda = 1'b0;
    sb.push_back('{"mc_change_no_viol", 8'b1110_1100});
    tick(1);
    e = sb.pop_front(); checks++;
    if (obs !== e.val) begin failures++; $display("FAIL %s: got %b expected %b", e.name, obs, e.val); end
    sda = 1'b1;
    sb.push_back('{"mc_mid_sticky", 8'b1111_1100});
    tick(1);
    e = sb.pop_front(); checks++;
    if (obs !== e.val) begin failures++; $display("FAIL %s: got %b expected %b", e.name, obs, e.val); end
    scl = 1'b0;
    sb.push_back('{"mc_hold", 8'b1111_0110});
    tick(1);
    e = sb.pop_front(); checks++;
    if (obs !== e.val) begin failures++; $display("FAIL %s: got %b expected %b", e.name, obs, e.val); end
  endtask

  task automatic test_start_priority();
    start_rx = 1'b1; rx_frm_slv = 1'b0; tx_done = 1'b1;
    sb.push_back('{"prio_start_over_txdone", 8'b0101_0100});
    tick(1);
    start_rx = 1'b0; tx_done = 1'b0;
    e = sb.pop_front(); checks++;
    if (obs !== e.val) begin failures++; $display("FAIL %s: got %b expected %b", e.name, obs, e.val); end
  endtask

  initial begin
    test_reset();
    test_master_bit();
    test_slave_bit();
    test_slave_violation();
    test_master_change();
    test_start_priority();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
